// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode constants, instruction field positions and
// the fetch-stage state encoding. Imported by the fetch unit and its helpers.
package sisc_pkg;

  localparam logic [3:0] NOOP   = 4'h0;
  localparam logic [3:0] LOD    = 4'h1;
  localparam logic [3:0] STR    = 4'h2;
  localparam logic [3:0] BRA    = 4'h4;
  localparam logic [3:0] BRR    = 4'h5;
  localparam logic [3:0] BNE    = 4'h6;
  localparam logic [3:0] ALU_OP = 4'h8;
  localparam logic [3:0] HLT    = 4'hF;

  localparam int OPC_MSB = 31;
  localparam int MM_MSB  = 27;
  localparam int IMM_MSB = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  function automatic logic [3:0] ir_opcode(input logic [31:0] ir_word);
    return ir_word[OPC_MSB -: 4];
  endfunction

  function automatic logic [3:0] ir_mm(input logic [31:0] ir_word);
    return ir_word[MM_MSB -: 4];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
// Handshake: master raises imem_rd with imem_addr held stable until the read
// completes; memory answers with a single-cycle imem_valid carrying imem_data,
// at least one cycle after imem_rd first rises. There is no backpressure.
interface fetch_unit_if #(
  parameter int AW = 16
);

  logic          imem_rd;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          imem_valid;

  modport master (
    output imem_rd,
    output imem_addr,
    input  imem_data,
    input  imem_valid
  );

  modport slave (
    input  imem_rd,
    input  imem_addr,
    output imem_data,
    output imem_valid
  );

endinterface

// File: rtl/fetch_unit_br_cond.sv
// Branch condition evaluation: decides from opcode, mask field and status
// flags whether a BRA/BRR/BNE instruction is taken.
module br_cond
  import sisc_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic [3:0] mm_i,
  input  logic [3:0] stat_i,
  output logic       take_o
);

  logic cond;

  always_comb begin
    take_o = 1'b0;
    cond   = |(stat_i & mm_i);
    case (opcode_i)
      BRA, BRR: take_o = (mm_i == 4'd0) || cond;
      BNE:      take_o = !cond;
      default:  take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// SISC instruction fetch stage: PC, IR, memory fetch FSM and branch resolve.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import sisc_pkg::*;
#(
  parameter int AW = 16
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic                clk,
  input  logic                rst_f,
  input  logic                fetch_start,
  input  logic                br_eval,
  input  logic [3:0]          stat,
  fetch_unit_if.master        imem,
  output logic [31:0]         ir,
  output logic [3:0]          opcode,
  output logic [3:0]          mm,
  output logic                ir_valid,
  output logic                busy,
  output logic [AW-1:0]       pc,
  output logic                br_taken,
  output logic                fetch_err,
  output fetch_state_e        dbg_state
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] fa_q, fa_d;
  logic [31:0]   ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic          br_taken_q, br_taken_d;

  logic [3:0]    opc_w;
  logic [3:0]    mm_w;
  logic [15:0]   imm_w;
  logic          take;
  logic [AW-1:0] br_target;
  logic          rd;
  logic [AW-1:0] addr;
  logic          timeout;

  assign opc_w = ir_opcode(ir_q);
  assign mm_w  = ir_mm(ir_q);
  assign imm_w = ir_q[IMM_MSB -: 16];

  br_cond u_br_cond (
    .opcode_i (opc_w),
    .mm_i     (mm_w),
    .stat_i   (stat),
    .take_o   (take)
  );

  // AW never exceeds 16, so adding the low AW bits of the immediate equals
  // adding its sign extension modulo 2^AW.
  always_comb begin
    br_target = ir_q[AW-1:0];
    if (opc_w == BRR) br_target = pc_q + imm_w[AW-1:0];
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout = (state_q == WAIT) && !imem.imem_valid &&
                   (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if ((state_q == WAIT) && !imem.imem_valid && !timeout) cnt_d = cnt_q + CNT_W'(1);
    err_d = err_q | timeout;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fa_d       = fa_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    br_taken_d = br_taken_q;
    rd         = 1'b0;
    addr       = fa_q;

    case (state_q)
      IDLE: begin
        if (fetch_start) state_d = REQ;
      end
      REQ: begin
        rd      = 1'b1;
        addr    = pc_q;
        fa_d    = pc_q;
        state_d = WAIT;
      end
      WAIT: begin
        rd = 1'b1;
        if (imem.imem_valid) begin
          ir_d       = imem.imem_data;
          pc_d       = fa_q + AW'(1);
          ir_valid_d = 1'b1;
          state_d    = IDLE;
        end else if (timeout) begin
          ir_d       = {NOOP, 28'd0};
          pc_d       = fa_q + AW'(1);
          ir_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A taken branch overrides the post-fetch increment; the in-flight fetch
    // still completes from its latched address.
    if (br_eval) begin
      br_taken_d = take;
      if (take) pc_d = br_target;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      fa_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fa_q       <= fa_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign imem.imem_rd   = rd;
  assign imem.imem_addr = addr;

  assign ir        = ir_q;
  assign opcode    = opc_w;
  assign mm        = mm_w;
  assign ir_valid  = ir_valid_q;
  assign busy      = (state_q != IDLE);
  assign pc        = pc_q;
  assign br_taken  = br_taken_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized fetch/branch
// traffic, checked against a behavioural PC/IR model.
module tb_fetch_unit;
  import sisc_pkg::*;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_f = 1'b0;
  logic          fetch_start = 1'b0;
  logic          br_eval = 1'b0;
  logic [3:0]    stat = 4'd0;
  logic [31:0]   ir;
  logic [3:0]    opcode;
  logic [3:0]    mm;
  logic          ir_valid;
  logic          busy;
  logic [AW-1:0] pc;
  logic          br_taken;
  logic          fetch_err;
  fetch_state_e  dbg_state;

  fetch_unit_if #(.AW(AW)) imem ();

  fetch_unit #(.AW(AW)) dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .fetch_start (fetch_start),
    .br_eval     (br_eval),
    .stat        (stat),
    .imem        (imem),
    .ir          (ir),
    .opcode      (opcode),
    .mm          (mm),
    .ir_valid    (ir_valid),
    .busy        (busy),
    .pc          (pc),
    .br_taken    (br_taken),
    .fetch_err   (fetch_err),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [31:0]   m_ir = '0;
  logic [AW-1:0] m_pc = '0;
  logic          m_br = 1'b0;
  logic          m_err = 1'b0;
  logic [31:0]   exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Branch rules applied to the model's current IR and PC.
  task automatic model_branch(input logic [3:0] s, output logic take, output logic [AW-1:0] tgt);
    logic [31:0] w;
    int op, msk, imm;
    bit cond;
    w    = m_ir;
    op   = int'(w[31:28]);
    msk  = int'(w[27:24]);
    imm  = int'($signed(w[15:0]));
    cond = (int'(s) & msk) != 0;
    take = 1'b0;
    tgt  = w[AW-1:0];
    if (op == 4)      take = (msk == 0) || cond;
    else if (op == 5) begin
      take = (msk == 0) || cond;
      tgt  = AW'(int'(m_pc) + imm);
    end
    else if (op == 6) take = !cond;
  endtask

  task automatic do_br(input logic [3:0] s);
    logic take;
    logic [AW-1:0] tgt;
    @(negedge clk);
    stat = s;
    br_eval = 1'b1;
    model_branch(s, take, tgt);
    @(negedge clk);
    br_eval = 1'b0;
    m_br = take;
    if (take) m_pc = tgt;
    chk("br_pc", 32'(pc), 32'(m_pc));
    chk("br_taken", 32'(br_taken), 32'(m_br));
  endtask

  // br_at: cycle index (0..lat) at which br_eval pulses during the fetch, -1 for none;
  // br_at == lat coincides with imem_valid. dup pulses a second fetch_start mid-fetch.
  task automatic do_fetch(input logic [31:0] data, input int lat, input int br_at,
                          input logic [3:0] bs, input bit dup);
    logic [AW-1:0] fa;
    logic take;
    logic [AW-1:0] tgt;
    fa = m_pc;
    take = 1'b0;
    tgt = '0;
    exp_q.push_back(data);
    @(negedge clk);
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    chk("req_rd", 32'(imem.imem_rd), 32'd1);
    chk("req_addr", 32'(imem.imem_addr), 32'(fa));
    chk("req_busy", 32'(busy), 32'd1);
    for (int i = 0; i < lat; i++) begin
      if (br_at == i) begin
        stat = bs;
        br_eval = 1'b1;
        model_branch(bs, take, tgt);
      end
      if (dup && i == lat - 1) fetch_start = 1'b1;
      @(negedge clk);
      br_eval = 1'b0;
      fetch_start = 1'b0;
      if (br_at == i) begin
        m_br = take;
        if (take) m_pc = tgt;
        chk("busy_br_pc", 32'(pc), 32'(m_pc));
        chk("busy_br_taken", 32'(br_taken), 32'(m_br));
      end
      chk("wait_rd", 32'(imem.imem_rd), 32'd1);
      chk("wait_addr", 32'(imem.imem_addr), 32'(fa));
      chk("wait_irv", 32'(ir_valid), 32'd0);
    end
    imem.imem_valid = 1'b1;
    imem.imem_data = data;
    if (br_at == lat) begin
      stat = bs;
      br_eval = 1'b1;
      model_branch(bs, take, tgt);
    end
    @(negedge clk);
    imem.imem_valid = 1'b0;
    imem.imem_data = $urandom;
    br_eval = 1'b0;
    m_ir = exp_q.pop_front();
    m_pc = fa + AW'(1);
    if (br_at == lat) begin
      m_br = take;
      if (take) m_pc = tgt;
    end
    chk("done_irv", 32'(ir_valid), 32'd1);
    chk("done_ir", ir, m_ir);
    chk("done_opcode", 32'(opcode), {28'd0, m_ir[31:28]});
    chk("done_mm", 32'(mm), {28'd0, m_ir[27:24]});
    chk("done_pc", 32'(pc), 32'(m_pc));
    chk("done_br_taken", 32'(br_taken), 32'(m_br));
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_err", 32'(fetch_err), 32'(m_err));
    @(negedge clk);
    chk("post_irv", 32'(ir_valid), 32'd0);
    chk("post_rd", 32'(imem.imem_rd), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ir"}, ir, 32'd0);
    chk({tag, "_pc"}, 32'(pc), 32'd0);
    chk({tag, "_rd"}, 32'(imem.imem_rd), 32'd0);
    chk({tag, "_irv"}, 32'(ir_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_brt"}, 32'(br_taken), 32'd0);
    chk({tag, "_err"}, 32'(fetch_err), 32'd0);
  endtask

  logic [31:0]   rnd_d;
  int            rnd_lat;
  int            rnd_br;
  logic [AW-1:0] to_fa;

  initial begin
    imem.imem_valid = 1'b0;
    imem.imem_data = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_f = 1'b1;

    // Basic fetch, memory latency 3
    do_fetch(32'h8000_0000, 3, -1, 4'd0, 1'b0);

    // BRA with mask: taken, then not taken
    do_fetch(32'h4800_0020, 2, -1, 4'd0, 1'b0);
    do_br(4'b1000);
    do_br(4'b0000);

    // BRR relative, including wrap past the top of the address space
    do_fetch(32'h4000_0010, 1, -1, 4'd0, 1'b0);
    do_br(4'd0);
    do_fetch(32'h5100_FFF0, 2, -1, 4'd0, 1'b0);
    do_br(4'd1);
    do_fetch(32'h4000_FFFE, 1, -1, 4'd0, 1'b0);
    do_br(4'd0);
    do_fetch(32'h5100_0002, 1, -1, 4'd0, 1'b0);
    do_br(4'd1);

    // PC increment wrap
    do_fetch(32'h4000_FFFF, 1, -1, 4'd0, 1'b0);
    do_br(4'd0);
    do_fetch(32'h0000_0000, 2, -1, 4'd0, 1'b0);

    // BNE
    do_fetch(32'h6100_0040, 1, -1, 4'd0, 1'b0);
    do_br(4'd0);
    do_br(4'd1);

    // Branch coinciding with fetch completion, then branch while busy
    do_fetch(32'h4000_1234, 2, -1, 4'd0, 1'b0);
    do_fetch(32'h1234_5678, 3, 3, 4'd0, 1'b0);
    do_fetch(32'h4000_0100, 2, -1, 4'd0, 1'b0);
    do_fetch(32'h2000_0000, 3, 1, 4'd0, 1'b0);

    // Duplicate fetch_start during WAIT is ignored
    do_fetch(32'h2000_0000, 4, -1, 4'd0, 1'b1);

    // Reset mid-fetch, followed by a stale imem_valid
    @(negedge clk);
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    @(negedge clk);
    rst_f = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst_f = 1'b1;
    imem.imem_valid = 1'b1;
    imem.imem_data = 32'hDEAD_BEEF;
    @(negedge clk);
    imem.imem_valid = 1'b0;
    chk("stale_irv", 32'(ir_valid), 32'd0);
    chk("stale_ir", ir, 32'd0);
    chk("stale_pc", 32'(pc), 32'd0);
    chk("stale_busy", 32'(busy), 32'd0);
    m_ir = '0;
    m_pc = '0;
    m_br = 1'b0;
    m_err = 1'b0;
    exp_q.delete();

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: timeout after 15 WAIT cycles
    to_fa = m_pc;
    @(negedge clk);
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("to_wait_irv", 32'(ir_valid), 32'd0);
      chk("to_wait_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    m_ir = '0;
    m_pc = to_fa + AW'(1);
    m_err = 1'b1;
    chk("to_irv", 32'(ir_valid), 32'd1);
    chk("to_ir", ir, m_ir);
    chk("to_pc", 32'(pc), 32'(m_pc));
    chk("to_err", 32'(fetch_err), 32'd1);
`else
    // Slow memory with no timeout: fetch simply waits
    to_fa = m_pc;
    do_fetch(32'hA5A5_A5A5, 20, -1, 4'd0, 1'b0);
    chk("slow_pc", 32'(pc), 32'(to_fa + AW'(1)));
`endif

    // Randomized fetch/branch traffic
    for (int n = 0; n < 30; n++) begin
      rnd_d = $urandom;
      case ($urandom_range(0, 3))
        0: rnd_d[31:28] = BRA;
        1: rnd_d[31:28] = BRR;
        2: rnd_d[31:28] = BNE;
        default: ;
      endcase
      rnd_lat = int'($urandom_range(1, 4));
      rnd_br = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rnd_lat)) : -1;
      do_fetch(rnd_d, rnd_lat, rnd_br, 4'($urandom_range(0, 15)), 1'b0);
      do_br(4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
